// File: rtl/fxp_mul_if.sv
// Handshake and data bundle for the fxp_mul sequential fixed-point multiplier.
//   start       : request a multiply (master -> slave)
//   a, b        : signed Q(WIDTH-FBITS).FBITS operands (master -> slave)
//   busy        : calculation in progress (slave -> master)
//   done        : one-cycle completion pulse (slave -> master)
//   valid       : val holds a correct result (slave -> master)
//   ovf         : result not representable (slave -> master)
//   val         : signed product, same Q format (slave -> master)
interface fxp_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             valid;
  logic             ovf;
  logic [WIDTH-1:0] val;

  modport master (
    output start, a, b,
    input  busy, done, valid, ovf, val
  );

  modport slave (
    input  start, a, b,
    output busy, done, valid, ovf, val
  );
endinterface

// File: rtl/fxp_mul.sv
// Sequential signed fixed-point multiplier. Magnitudes are multiplied with a one-bit-per-cycle
// shift-add, the full-width product is rounded half-to-even back to the operand Q format, then
// the sign is reapplied. Unrepresentable results saturate and raise ovf.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fxp_mul_if slave (start/a/b in; busy/done/valid/ovf/val out)
module fxp_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 16
) (
  input logic      clk,
  input logic      rst_n,
  fxp_mul_if.slave bus
);

  localparam int unsigned WIDTHU = WIDTH - 1;
  localparam int unsigned PW     = 2 * WIDTHU;       // exact magnitude product width
  localparam int unsigned QW     = PW - FBITS + 1;   // rounded quotient plus carry bit
  localparam int unsigned IW     = $clog2(WIDTHU);

  localparam logic [WIDTH-1:0] SMALLEST = {1'b1, {WIDTHU{1'b0}}};
  localparam logic [WIDTH-1:0] POS_SAT  = {1'b0, {WIDTHU{1'b1}}};
  localparam logic [WIDTH-1:0] NEG_SAT  = {1'b1, {(WIDTHU - 1){1'b0}}, 1'b1};
  localparam logic [FBITS-1:0] HALF     = FBITS'(1) << (FBITS - 1);
  localparam logic [IW-1:0]    I_LAST   = IW'(WIDTHU - 1);

  typedef enum logic [2:0] {StIdle, StInit, StCalc, StRound, StSign} state_e;

  state_e            state_q;
  logic [PW-1:0]     p_q;
  logic [PW-1:0]     au_q;      // multiplicand, shifted left each CALC cycle
  logic [WIDTHU-1:0] bu_q;      // multiplier, shifted right each CALC cycle
  logic [IW-1:0]     i_q;
  logic              sig_diff_q;
  logic [WIDTHU-1:0] q_q;

  logic [WIDTHU-1:0] a_mag;
  logic [WIDTHU-1:0] b_mag;
  logic [QW-2:0]     q_raw;
  logic [FBITS-1:0]  r_frac;
  logic              round_up;
  logic [QW-1:0]     q_rnd;
  logic              rnd_ovf;

  // SMALLEST is filtered out before these are used, so the magnitude always fits in WIDTHU bits.
  assign a_mag = WIDTHU'(bus.a[WIDTH-1] ? -bus.a : bus.a);
  assign b_mag = WIDTHU'(bus.b[WIDTH-1] ? -bus.b : bus.b);

  assign q_raw    = p_q[PW-1:FBITS];
  assign r_frac   = p_q[FBITS-1:0];
  assign round_up = (r_frac > HALF) || ((r_frac == HALF) && q_raw[0]);
  assign q_rnd    = {1'b0, q_raw} + QW'(round_up);
  assign rnd_ovf  = |q_rnd[QW-1:WIDTHU];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.valid  <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.val    <= '0;
      p_q        <= '0;
      au_q       <= '0;
      bu_q       <= '0;
      i_q        <= '0;
      sig_diff_q <= 1'b0;
      q_q        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.a == SMALLEST || bus.b == SMALLEST) begin
              // |SMALLEST| has no positive representation
              bus.ovf   <= 1'b1;
              bus.done  <= 1'b1;
              bus.valid <= 1'b0;
              bus.busy  <= 1'b0;
              bus.val   <= '0;
            end else if (bus.a == '0 || bus.b == '0) begin
              bus.val   <= '0;
              bus.valid <= 1'b1;
              bus.done  <= 1'b1;
              bus.ovf   <= 1'b0;
              bus.busy  <= 1'b0;
            end else begin
              au_q       <= PW'(a_mag);
              bu_q       <= b_mag;
              sig_diff_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              bus.busy   <= 1'b1;
              bus.valid  <= 1'b0;
              bus.ovf    <= 1'b0;
              state_q    <= StInit;
            end
          end
        end
        StInit: begin
          p_q     <= '0;
          i_q     <= '0;
          state_q <= StCalc;
        end
        StCalc: begin
          p_q  <= p_q + (bu_q[0] ? au_q : '0);
          au_q <= au_q << 1;
          bu_q <= bu_q >> 1;
          i_q  <= i_q + 1'b1;
          if (i_q == I_LAST) state_q <= StRound;
        end
        StRound: begin
          if (rnd_ovf) begin
            bus.ovf   <= 1'b1;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.val   <= sig_diff_q ? NEG_SAT : POS_SAT;
            state_q   <= StIdle;
          end else begin
            q_q     <= q_rnd[WIDTHU-1:0];
            state_q <= StSign;
          end
        end
        StSign: begin
          // a zero magnitude stays positive zero regardless of operand signs
          bus.val   <= (sig_diff_q && q_q != '0) ? -{1'b0, q_q} : {1'b0, q_q};
          bus.done  <= 1'b1;
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mul.sv
module tb_fxp_mul;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fxp_mul_if #(.WIDTH(32)) bus ();

  fxp_mul #(
    .WIDTH(32),
    .FBITS(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one cycle and count edges after the accepting edge until done.
  // lat == 100 means done never arrived.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.valid !== 1'b0 || bus.ovf !== 1'b0 || bus.val !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ovf=%b val=%h want 0 0 0",
               bus.valid, bus.ovf, bus.val);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h00020000, 32'h00030000, lat);
    n_checks++;
    if (lat !== 34) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 34", lat);
    end
    n_checks++;
    if (bus.val !== 32'h00060000 || bus.valid !== 1'b1 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got val=%h valid=%b ovf=%b want 00060000 1 0",
               bus.val, bus.valid, bus.ovf);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%b want 0", bus.done);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b1 || bus.val !== 32'h00060000) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b val=%h want 1 00060000", bus.valid, bus.val);
    end
  endtask

  task automatic test_negative();
    int lat;
    run_op(32'hFFFE8000, 32'h00020000, lat);
    n_checks++;
    if (lat !== 34 || bus.val !== 32'hFFFD0000 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL negative: got lat=%0d val=%h valid=%b want 34 FFFD0000 1",
               lat, bus.val, bus.valid);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] av  [3] = '{32'h00000001, 32'h00000003, 32'hFFFFFFFF};
    logic [31:0] exp [3] = '{32'h00000000, 32'h00000002, 32'h00000000};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(av[k], 32'h00008000, lat);
      n_checks++;
      if (lat !== 34 || bus.val !== exp[k] || bus.valid !== 1'b1 || bus.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL rounding_%0d: got lat=%0d val=%h valid=%b ovf=%b want 34 %h 1 0",
                 k, lat, bus.val, bus.valid, bus.ovf, exp[k]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h01000000, 32'h01000000, lat);
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL ovf_pos_latency: got %0d want 33", lat);
    end
    n_checks++;
    if (bus.ovf !== 1'b1 || bus.valid !== 1'b0 || bus.val !== 32'h7FFFFFFF) begin
      n_fail++;
      $display("FAIL ovf_pos_result: got ovf=%b valid=%b val=%h want 1 0 7FFFFFFF",
               bus.ovf, bus.valid, bus.val);
    end
    run_op(32'hFF000000, 32'h01000000, lat);
    n_checks++;
    if (lat !== 33 || bus.ovf !== 1'b1 || bus.val !== 32'h80000001) begin
      n_fail++;
      $display("FAIL ovf_neg: got lat=%0d ovf=%b val=%h want 33 1 80000001",
               lat, bus.ovf, bus.val);
    end
    run_op(32'h80000000, 32'h00010000, lat);
    n_checks++;
    if (lat !== 0 || bus.ovf !== 1'b1 || bus.valid !== 1'b0 || bus.val !== 32'h0 ||
        bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_smallest: got lat=%0d ovf=%b valid=%b val=%h busy=%b want 0 1 0 0 0",
               lat, bus.ovf, bus.valid, bus.val, bus.busy);
    end
  endtask

  task automatic test_zero();
    int lat;
    run_op(32'h00000000, 32'h12345678, lat);
    n_checks++;
    if (lat !== 0 || bus.val !== 32'h0 || bus.valid !== 1'b1 || bus.ovf !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero: got lat=%0d val=%h valid=%b ovf=%b busy=%b want 0 0 1 0 0",
               lat, bus.val, bus.valid, bus.ovf, bus.busy);
    end
  endtask

  // Second start lands in the cycle done is high.
  task automatic test_back_to_back();
    int lat;
    run_op(32'h00010000, 32'h00050000, lat);
    n_checks++;
    if (lat !== 34 || bus.val !== 32'h00050000) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d val=%h want 34 00050000", lat, bus.val);
    end
    run_op(32'hFFFF0000, 32'h00040000, lat);
    n_checks++;
    if (lat !== 34 || bus.val !== 32'hFFFC0000 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d val=%h valid=%b want 34 FFFC0000 1",
               lat, bus.val, bus.valid);
    end
  endtask

  task automatic test_start_ignore();
    int lat;
    @(negedge clk);
    bus.a     = 32'h00020000;
    bus.b     = 32'h00030000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_flags: got busy=%b valid=%b done=%b want 1 0 0",
               bus.busy, bus.valid, bus.done);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      bus.a     = 32'h80000000;
      bus.b     = 32'h00000007;
      bus.start = (lat % 3 == 0);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat !== 34 || bus.val !== 32'h00060000 || bus.ovf !== 1'b0 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignore: got lat=%0d val=%h ovf=%b valid=%b want 34 00060000 0 1",
               lat, bus.val, bus.ovf, bus.valid);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    bus.a     = 32'h00020000;
    bus.b     = 32'h00020000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);  // now in CALC with i == 10
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.val !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b valid=%b ovf=%b val=%h want all 0",
               bus.busy, bus.done, bus.valid, bus.ovf, bus.val);
    end
    repeat (3) @(posedge clk);
    // start is already high on the first edge after release
    @(negedge clk);
    rst_n     = 1'b1;
    bus.a     = 32'h00020000;
    bus.b     = 32'h00020000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_accept: got busy=%b want 1", bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 34 || bus.val !== 32'h00040000 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d val=%h valid=%b want 34 00040000 1",
               lat, bus.val, bus.valid);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_basic();
    test_negative();
    test_rounding();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_start_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
